load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory initiator that produces the `mem_in` operand consumed by the write-back select stage.
- Accepts one load/store per handshake from execute and drives a valid/ready data-memory bus.
- For loads, aligns and sign/zero-extends the returned word into an `arch_reg`. For stores, it generates lane data and byte enables.
- Single outstanding transaction; sits between execute and write-back in the RV32 pipeline.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in WAIT before the transaction is aborted with `resp_fault=1`; must be 1..65535.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  execute presents a memory op
- req_ready  out  1  unit can accept (IDLE only)
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- req_addr  in  32  byte address
- req_wdata  in  32  store source (rs2)
- resp_valid  out  1  result available to write-back
- resp_ready  in  1  write-back consumes result
- resp_data  out  32  arch_reg load result (0 for stores/faults)
- resp_misaligned  out  1  request was misaligned, no bus access made
- resp_fault  out  1  bus timeout
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address (req_addr[31:2],2'b00)
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_rsp_valid  in  1  bus response (read data or write ack)
- mem_rsp_rdata  in  32  read word

Behaviour:
- Reset (async, any state): state=IDLE and all outputs 0, except `req_ready=1`. A transaction in flight is dropped; a later stray `mem_rsp_valid` in IDLE is ignored.

State IDLE:
- `req_ready=1`.
- On `req_valid`, latch is_store, funct3, addr[1:0], wdata and word address.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0.
- If misaligned, or funct3 is an illegal encoding (011, 110, 111; 100/101 for stores):
  - go to RESP.
  - `resp_misaligned=1`, `resp_data=0`.
  - No bus request.
- Otherwise go to REQ.

State REQ:
- `mem_req_valid=1`; `mem_addr`, `mem_we`, `mem_wdata` and `mem_be` are held stable until `mem_req_ready`, then go to WAIT.
- The timeout counter runs in REQ and WAIT combined.
- Byte enables:
  - byte: `mem_be = 4'b0001 << addr[1:0]`
  - half: `mem_be = 4'b0011 << addr[1:0]`
  - word: `mem_be = 4'b1111`
- Write data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- For loads, `mem_be` reflects the access size, `mem_we=0` and `mem_wdata=0`.

State WAIT:
- On `mem_rsp_valid`, capture the extended result and go to RESP.
- Load extraction from the response word:
  - byte: lane = `rdata >> (8*addr[1:0])`
  - half: lane = `rdata >> (8*addr[1:0])`
  - LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- Stores: `resp_data=0`.
- Counter reaching TIMEOUT_CYCLES without a response: go to RESP with `resp_fault=1`, `resp_data=0`. A late response after that is ignored.

State RESP:
- `resp_valid=1`; data and flags held stable until `resp_ready`, then go to IDLE.
- `req_ready` is 0, so there is no same-cycle back-to-back acceptance.
- Minimum load latency: request accepted in cycle 0, REQ in cycle 1, WAIT in cycle 2; with the response in cycle 2, `resp_valid` rises in cycle 3.

Simultaneous events:
- `mem_req_ready` and `mem_rsp_valid` in the same REQ cycle: the response is accepted and the unit goes straight to RESP.
- A response on the timeout-expiry cycle wins over the fault.

Decomposition:
- `lsu_pkg` holds:
  - the `lsu_state_t` enum (IDLE/REQ/WAIT/RESP)
  - `mem_size_t` localparams for funct3 encodings
- `arch_reg` comes from `instructions_pkg`.
- One natural sub-module, `load_align_extend`, which is pure combinational:
  - inputs: rdata, addr[1:0], funct3
  - output: 32-bit result
  - verified standalone.

Test Plan:
1. LB at addr 0x1003, bus returns 0x80FF_0000 after 2 cycles -> `mem_addr=0x1000`, `mem_be=4'b1000`, `resp_data=0xFFFF_FF80`; LBU at the same address -> `0x0000_0080`.
2. SH at 0x2002 with wdata 0x1234_ABCD -> `mem_we=1`, `mem_be=4'b1100`, `mem_wdata=0xABCD_ABCD`, `resp_valid` after ack with `resp_data=0`.
3. LW at 0x3001 -> no `mem_req_valid` ever; `resp_valid=1` with `resp_misaligned=1` and `resp_data=0` one cycle after acceptance.
4. LW, bus never responds, TIMEOUT_CYCLES=4 -> `resp_fault=1` exactly 4 cycles after entering REQ; a stray `mem_rsp_valid` afterwards is ignored in IDLE.
5. `mem_req_ready` held 0 for 3 cycles -> address, be and data stable across the stall. With `resp_ready=0`, `resp_valid`/`resp_data` are held and `req_ready` stays 0.
6. Assert `rst` mid-WAIT -> outputs immediately 0 with `req_ready=1`; next LHU at 0x0 with rdata 0x0000_8001 returns `0x0000_8001`.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the RV32 load/store unit: FSM states,
// funct3 size encodings and the per-request decode helpers.
package load_store_unit_pkg;

    // Architectural register value as seen by write-back.
    typedef logic [31:0] arch_reg;

    // Transaction sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // funct3 encodings for the access size / extension.
    typedef logic [2:0] mem_size_t;
    localparam mem_size_t SIZE_B  = 3'b000;
    localparam mem_size_t SIZE_H  = 3'b001;
    localparam mem_size_t SIZE_W  = 3'b010;
    localparam mem_size_t SIZE_BU = 3'b100;
    localparam mem_size_t SIZE_HU = 3'b101;

    // Unsigned variants only exist for loads.
    function automatic logic funct3_legal(input logic is_store, input mem_size_t f3);
        logic ok;
        case (f3)
            SIZE_B, SIZE_H, SIZE_W: ok = 1'b1;
            SIZE_BU, SIZE_HU:       ok = ~is_store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Halves need an even address, words a word-aligned address.
    function automatic logic addr_misaligned(input mem_size_t f3, input logic [1:0] a);
        logic mis;
        case (f3)
            SIZE_H, SIZE_HU: mis = a[0];
            SIZE_W:          mis = (a != 2'b00);
            default:         mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Byte lanes touched by the access.
    function automatic logic [3:0] byte_enables(input mem_size_t f3, input logic [1:0] a);
        logic [3:0] be;
        case (f3)
            SIZE_B, SIZE_BU: be = 4'b0001 << a;
            SIZE_H, SIZE_HU: be = 4'b0011 << a;
            SIZE_W:          be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate store data across all lanes so the byte enables pick the right copy.
    function automatic logic [31:0] store_lanes(input mem_size_t f3, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (f3)
            SIZE_B:  lanes = {4{wdata[7:0]}};
            SIZE_H:  lanes = {2{wdata[15:0]}};
            SIZE_W:  lanes = wdata;
            default: lanes = 32'h0000_0000;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request, write-back response and data-memory bus of the
// load/store unit. The master view is the unit itself; slave is its environment.
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    arch_reg     resp_data;
    logic        resp_misaligned;
    logic        resp_fault;

    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport master (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_data, resp_misaligned, resp_fault,
        input  resp_ready,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_data, resp_misaligned, resp_fault,
        output resp_ready,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

endinterface

// File: rtl/load_store_unit_load_align_extend.sv
// Pure combinational load formatter: moves the addressed lane of the read
// word down to bit 0 and sign- or zero-extends it to a full register.
module load_align_extend
    import load_store_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  mem_size_t   funct3,
    output arch_reg     result
);

    logic [31:0] shifted_s;

    // Select the lane by byte offset, then extend according to funct3.
    always_comb begin
        shifted_s = rdata >> {addr_lo, 3'b000};
        case (funct3)
            SIZE_B:  result = {{24{shifted_s[7]}}, shifted_s[7:0]};
            SIZE_H:  result = {{16{shifted_s[15]}}, shifted_s[15:0]};
            SIZE_W:  result = rdata;
            SIZE_BU: result = {24'h00_0000, shifted_s[7:0]};
            SIZE_HU: result = {16'h0000, shifted_s[15:0]};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32 load/store unit: one outstanding data-memory transaction between
// execute and write-back, with alignment checks, lane steering for stores,
// load extension and a bus timeout.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.master bus
);

    // Counter value on the last cycle allowed before the abort.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_r;
    lsu_state_t  state_next_s;

    logic        is_store_r;
    mem_size_t   funct3_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_be_r;
    logic        mem_we_r;
    logic [15:0] tmo_cnt_r;

    arch_reg     resp_data_r;
    logic        resp_misaligned_r;
    logic        resp_fault_r;

    logic        req_ready_r;
    logic        mem_req_valid_r;
    logic        resp_valid_r;

    logic        req_bad_s;
    logic        expire_s;
    logic        accept_s;
    logic        capture_s;
    logic        timeout_s;
    arch_reg     load_result_s;

    load_align_extend u_align (
        .rdata   (bus.mem_rsp_rdata),
        .addr_lo (addr_lo_r),
        .funct3  (funct3_r),
        .result  (load_result_s)
    );

    // Decode the incoming request and the timeout condition.
    always_comb begin
        req_bad_s = ~funct3_legal(bus.req_is_store, bus.req_funct3) |
                    addr_misaligned(bus.req_funct3, bus.req_addr[1:0]);
        expire_s  = (tmo_cnt_r == TIMEOUT_LAST);
    end

    // Next-state logic and one-cycle event strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        capture_s    = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = req_bad_s ? RESP : REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                // A response arriving with the request handshake skips WAIT.
                if (bus.mem_req_ready && bus.mem_rsp_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = RESP;
                end else if (expire_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = RESP;
                end else if (bus.mem_req_ready) begin
                    state_next_s = WAIT;
                end else begin
                    state_next_s = REQ;
                end
            end
            WAIT: begin
                // A response on the expiry cycle takes priority over the fault.
                if (bus.mem_rsp_valid) begin
                    capture_s    = 1'b1;
                    state_next_s = RESP;
                end else if (expire_s) begin
                    timeout_s    = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = WAIT;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Handshake outputs registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r     <= 1'b1;
            mem_req_valid_r <= 1'b0;
            resp_valid_r    <= 1'b0;
        end else begin
            req_ready_r     <= (state_next_s == IDLE);
            mem_req_valid_r <= (state_next_s == REQ);
            resp_valid_r    <= (state_next_s == RESP);
        end
    end

    // Timeout counter: runs across REQ and WAIT, restarts everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_r <= 16'h0000;
        end else if ((state_r == REQ) || (state_r == WAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + 16'h0001;
        end else begin
            tmo_cnt_r <= 16'h0000;
        end
    end

    // Latch the request and precompute the bus beat at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_r  <= 1'b0;
            funct3_r    <= 3'b000;
            addr_lo_r   <= 2'b00;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            mem_we_r    <= 1'b0;
        end else if (accept_s) begin
            is_store_r  <= bus.req_is_store;
            funct3_r    <= bus.req_funct3;
            addr_lo_r   <= bus.req_addr[1:0];
            mem_addr_r  <= {bus.req_addr[31:2], 2'b00};
            mem_wdata_r <= bus.req_is_store ? store_lanes(bus.req_funct3, bus.req_wdata)
                                            : 32'h0000_0000;
            mem_be_r    <= byte_enables(bus.req_funct3, bus.req_addr[1:0]);
            mem_we_r    <= bus.req_is_store;
        end
    end

    // Response payload: cleared on acceptance, filled by a response or a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data_r       <= 32'h0000_0000;
            resp_misaligned_r <= 1'b0;
            resp_fault_r      <= 1'b0;
        end else if (accept_s) begin
            resp_data_r       <= 32'h0000_0000;
            resp_misaligned_r <= req_bad_s;
            resp_fault_r      <= 1'b0;
        end else if (capture_s) begin
            resp_data_r       <= is_store_r ? 32'h0000_0000 : load_result_s;
        end else if (timeout_s) begin
            resp_data_r       <= 32'h0000_0000;
            resp_fault_r      <= 1'b1;
        end
    end

    assign bus.req_ready       = req_ready_r;
    assign bus.resp_valid      = resp_valid_r;
    assign bus.resp_data       = resp_data_r;
    assign bus.resp_misaligned = resp_misaligned_r;
    assign bus.resp_fault      = resp_fault_r;
    assign bus.mem_req_valid   = mem_req_valid_r;
    assign bus.mem_we          = mem_we_r;
    assign bus.mem_addr        = mem_addr_r;
    assign bus.mem_wdata       = mem_wdata_r;
    assign bus.mem_be          = mem_be_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized
// transactions against an arithmetic reference model, and hand-written
// timeout / reset sequences.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    load_store_unit_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        st;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] rdata;
        int        stall;
        int        delay;
        int        hold;
        bit        exp_mis;
        bit [31:0] exp_addr;
        bit [3:0]  exp_be;
        bit [31:0] exp_wdata;
        bit [31:0] exp_data;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: derives expected bus beat and result from the ISA rules.
    function automatic vec_t model(input vec_t v);
        vec_t   e;
        int     size;
        bit     sgn;
        bit     legal;
        int     off;
        longint span;
        longint lane;
        longint rep;
        e = v;
        size = 4; sgn = 1'b0; legal = 1'b1;
        case (v.f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; end
            3'd4: begin size = 1; legal = !v.st; end
            3'd5: begin size = 2; legal = !v.st; end
            default: legal = 1'b0;
        endcase
        off = int'(v.addr % 32'd4);
        e.exp_mis   = !legal || ((v.addr % 32'(size)) != 32'd0);
        e.exp_addr  = v.addr - 32'(off);
        e.exp_be    = 4'(((1 << size) - 1) << off);
        span        = longint'(1) << (8 * size);
        rep         = ((longint'(1) << 32) - 1) / (span - 1);
        e.exp_wdata = v.st ? 32'((longint'(v.wdata) % span) * rep) : 32'd0;
        if (v.st || e.exp_mis) begin
            e.exp_data = 32'd0;
        end else begin
            lane = (longint'(v.rdata) / (longint'(1) << (8 * off))) % span;
            if (sgn && lane >= span / 2) lane = lane - span;
            e.exp_data = 32'(lane);
        end
        return e;
    endfunction

    // Drive one transaction through request, bus and response phases.
    task automatic run_txn(input vec_t v, input string tag);
        bus_if.req_valid    = 1'b1;
        bus_if.req_is_store = v.st;
        bus_if.req_funct3   = v.f3;
        bus_if.req_addr     = v.addr;
        bus_if.req_wdata    = v.wdata;
        chk({tag, ".req_ready"}, bus_if.req_ready, 32'd1);
        tick();
        bus_if.req_valid = 1'b0;
        bus_if.req_addr  = $urandom;
        bus_if.req_wdata = $urandom;
        if (!v.exp_mis) begin
            for (int i = 0; i <= v.stall; i++) begin
                chk({tag, ".mem_req_valid"}, bus_if.mem_req_valid, 32'd1);
                chk({tag, ".mem_addr"}, bus_if.mem_addr, v.exp_addr);
                chk({tag, ".mem_be"}, bus_if.mem_be, v.exp_be);
                chk({tag, ".mem_we"}, bus_if.mem_we, v.st);
                chk({tag, ".mem_wdata"}, bus_if.mem_wdata, v.exp_wdata);
                chk({tag, ".busy_ready"}, bus_if.req_ready, 32'd0);
                bus_if.mem_req_ready = (i == v.stall);
                bus_if.mem_rsp_valid = (i == v.stall) && (v.delay == 0);
                bus_if.mem_rsp_rdata = (i == v.stall) ? v.rdata : $urandom;
                tick();
            end
            bus_if.mem_req_ready = 1'b0;
            bus_if.mem_rsp_valid = 1'b0;
            for (int d = 1; d <= v.delay; d++) begin
                chk({tag, ".wait_req_valid"}, bus_if.mem_req_valid, 32'd0);
                chk({tag, ".wait_resp_valid"}, bus_if.resp_valid, 32'd0);
                bus_if.mem_rsp_valid = (d == v.delay);
                bus_if.mem_rsp_rdata = (d == v.delay) ? v.rdata : $urandom;
                tick();
            end
            bus_if.mem_rsp_valid = 1'b0;
            bus_if.mem_rsp_rdata = $urandom;
        end
        for (int h = 0; h <= v.hold; h++) begin
            chk({tag, ".resp_valid"}, bus_if.resp_valid, 32'd1);
            chk({tag, ".resp_data"}, bus_if.resp_data, v.exp_data);
            chk({tag, ".resp_mis"}, bus_if.resp_misaligned, v.exp_mis);
            chk({tag, ".resp_fault"}, bus_if.resp_fault, 32'd0);
            chk({tag, ".resp_req_ready"}, bus_if.req_ready, 32'd0);
            chk({tag, ".resp_mem_valid"}, bus_if.mem_req_valid, 32'd0);
            bus_if.resp_ready = (h == v.hold);
            tick();
        end
        bus_if.resp_ready = 1'b0;
        chk({tag, ".done_valid"}, bus_if.resp_valid, 32'd0);
        chk({tag, ".done_ready"}, bus_if.req_ready, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        vec_t v;
        bit [2:0] f3_pool[10];
        f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

        //           st    f3    addr          wdata         rdata         stl dly hld mis   exp_addr      be       exp_wdata     exp_data
        vecs[0]  = '{1'b0, 3'd0, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 2, 0, 1'b0, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 3'd4, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 2, 1, 1'b0, 32'h0000_1000, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[2]  = '{1'b1, 3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        0, 1, 0, 1'b0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[3]  = '{1'b0, 3'd2, 32'h0000_3001, 32'h0,        32'h0,         0, 0, 1, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 3'd2, 32'h0000_3004, 32'h0,        32'hDEAD_BEEF, 3, 0, 3, 1'b0, 32'h0000_3004, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 3'd0, 32'h0000_4001, 32'h0000_00A5, 32'h0,        0, 0, 0, 1'b0, 32'h0000_4000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[6]  = '{1'b0, 3'd1, 32'h0000_5002, 32'h0,        32'h8001_1234, 1, 2, 0, 1'b0, 32'h0000_5000, 4'b1100, 32'h0,        32'hFFFF_8001};
        vecs[7]  = '{1'b1, 3'd2, 32'h0000_6000, 32'hCAFE_F00D, 32'h0,        2, 1, 0, 1'b0, 32'h0000_6000, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[8]  = '{1'b1, 3'd4, 32'h0000_7000, 32'h1111_1111, 32'h0,        0, 0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 3'd3, 32'h0000_7000, 32'h0,        32'h0,         0, 0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b1, 3'd1, 32'h0000_7001, 32'h2222_2222, 32'h0,        0, 0, 0, 1'b1, 32'h0,         4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 3'd5, 32'h0000_7002, 32'h0,        32'hF00D_0000, 0, 3, 0, 1'b0, 32'h0000_7000, 4'b1100, 32'h0,        32'h0000_F00D};
        vecs[12] = '{1'b0, 3'd0, 32'h0000_8000, 32'h0,        32'h0000_007F, 0, 1, 0, 1'b0, 32'h0000_8000, 4'b0001, 32'h0,        32'h0000_007F};

        rst                 = 1'b1;
        bus_if.req_valid    = 1'b0;
        bus_if.req_is_store = 1'b0;
        bus_if.req_funct3   = 3'd0;
        bus_if.req_addr     = 32'd0;
        bus_if.req_wdata    = 32'd0;
        bus_if.resp_ready   = 1'b0;
        bus_if.mem_req_ready = 1'b0;
        bus_if.mem_rsp_valid = 1'b0;
        bus_if.mem_rsp_rdata = 32'd0;

        repeat (2) tick();
        chk("reset.req_ready", bus_if.req_ready, 32'd1);
        chk("reset.resp_valid", bus_if.resp_valid, 32'd0);
        chk("reset.mem_req_valid", bus_if.mem_req_valid, 32'd0);
        chk("reset.mem_be", bus_if.mem_be, 32'd0);
        chk("reset.resp_data", bus_if.resp_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed vectors.
        for (int k = 0; k < 13; k++) begin
            run_txn(vecs[k], $sformatf("vec%0d", k));
        end

        // Timeout while waiting for a response, then late and stray responses.
        bus_if.req_valid = 1'b1; bus_if.req_is_store = 1'b0;
        bus_if.req_funct3 = 3'd2; bus_if.req_addr = 32'h0000_0040;
        tick();
        bus_if.req_valid = 1'b0;
        bus_if.mem_req_ready = 1'b1;
        tick();
        bus_if.mem_req_ready = 1'b0;
        for (int c = 2; c <= TMO; c++) begin
            chk("tmo_wait.early_valid", bus_if.resp_valid, 32'd0);
            tick();
        end
        chk("tmo_wait.resp_valid", bus_if.resp_valid, 32'd1);
        chk("tmo_wait.resp_fault", bus_if.resp_fault, 32'd1);
        chk("tmo_wait.resp_data", bus_if.resp_data, 32'd0);
        chk("tmo_wait.resp_mis", bus_if.resp_misaligned, 32'd0);
        bus_if.mem_rsp_valid = 1'b1; bus_if.mem_rsp_rdata = 32'hFFFF_FFFF;
        tick();
        bus_if.mem_rsp_valid = 1'b0;
        chk("tmo_late.resp_data", bus_if.resp_data, 32'd0);
        chk("tmo_late.resp_fault", bus_if.resp_fault, 32'd1);
        bus_if.resp_ready = 1'b1;
        tick();
        bus_if.resp_ready = 1'b0;
        chk("tmo_done.req_ready", bus_if.req_ready, 32'd1);
        bus_if.mem_rsp_valid = 1'b1;
        tick();
        bus_if.mem_rsp_valid = 1'b0;
        chk("stray.resp_valid", bus_if.resp_valid, 32'd0);
        chk("stray.req_ready", bus_if.req_ready, 32'd1);
        chk("stray.mem_req_valid", bus_if.mem_req_valid, 32'd0);

        // Timeout while the bus never accepts the request.
        bus_if.req_valid = 1'b1; bus_if.req_is_store = 1'b1;
        bus_if.req_funct3 = 3'd2; bus_if.req_addr = 32'h0000_0080;
        bus_if.req_wdata = 32'h5555_AAAA;
        tick();
        bus_if.req_valid = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            chk("tmo_req.mem_req_valid", bus_if.mem_req_valid, 32'd1);
            chk("tmo_req.early_valid", bus_if.resp_valid, 32'd0);
            tick();
        end
        chk("tmo_req.resp_valid", bus_if.resp_valid, 32'd1);
        chk("tmo_req.resp_fault", bus_if.resp_fault, 32'd1);
        chk("tmo_req.mem_req_valid_off", bus_if.mem_req_valid, 32'd0);
        bus_if.resp_ready = 1'b1;
        tick();
        bus_if.resp_ready = 1'b0;

        // Reset in the middle of WAIT.
        bus_if.req_valid = 1'b1; bus_if.req_is_store = 1'b0;
        bus_if.req_funct3 = 3'd2; bus_if.req_addr = 32'h0000_0100;
        tick();
        bus_if.req_valid = 1'b0;
        bus_if.mem_req_ready = 1'b1;
        tick();
        bus_if.mem_req_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid.req_ready", bus_if.req_ready, 32'd1);
        chk("rst_mid.mem_req_valid", bus_if.mem_req_valid, 32'd0);
        chk("rst_mid.resp_valid", bus_if.resp_valid, 32'd0);
        chk("rst_mid.mem_addr", bus_if.mem_addr, 32'd0);
        chk("rst_mid.mem_be", bus_if.mem_be, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        v = '{1'b0, 3'd5, 32'h0000_0000, 32'h0, 32'h0000_8001, 0, 1, 0,
              1'b0, 32'h0000_0000, 4'b0011, 32'h0, 32'h0000_8001};
        run_txn(v, "post_rst_lhu");

        // Randomized transactions against the reference model.
        for (int n = 0; n < 60; n++) begin
            v.st    = 1'($urandom_range(0, 1));
            v.f3    = f3_pool[$urandom_range(0, 9)];
            v.addr  = $urandom;
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.stall = $urandom_range(0, 2);
            v.delay = $urandom_range(0, 3 - v.stall);
            v.hold  = $urandom_range(0, 2);
            v = model(v);
            run_txn(v, $sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
